// File: rtl/gate_chk_pkg.sv
// -----------------------------------------------------------------------------
// gate_chk_pkg
//   Shared definitions for the gate response checker: FSM state encoding,
//   MISR seed and feedback taps, and the reference gate function the checker
//   compares the board's gate outputs against.
// -----------------------------------------------------------------------------
package gate_chk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int unsigned     MISR_W    = 16;
   localparam logic [MISR_W-1:0] MISR_SEED = 16'hFFFF;
   // Feedback taps at bits 15, 14, 12 and 3.
   localparam logic [MISR_W-1:0] MISR_TAPS = 16'hD008;

   // Returns {e, f, g} as the gates should drive them for inputs a..d.
   function automatic logic [2:0] expected_efg(input logic a, input logic b,
                                               input logic c, input logic d);
      return {~(a & b), ~(c | d), a ^ b ^ c ^ d};
   endfunction

endpackage

// File: rtl/gate_chk_misr.sv
// -----------------------------------------------------------------------------
// gate_chk_misr
//   16-bit multiple-input signature register that folds each accepted 7-bit
//   vector into a running signature.
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous reset, active high (loads the seed)
//     load  in   reload the seed (start of a run); wins over en
//     en    in   compress din into the signature this edge
//     din   in   7-bit vector {a,b,c,d,e,f,g}
//     sig   out  current signature
// -----------------------------------------------------------------------------
module gate_chk_misr
   import gate_chk_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              en,
   input  logic [6:0]        din,
   output logic [MISR_W-1:0] sig
);

   logic [MISR_W-1:0] sig_q;
   logic [MISR_W-1:0] sig_d;
   logic              fb;

   // NOTE: every variable gets a default at the top of always_comb so that no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      fb    = ^(sig_q & MISR_TAPS);
      sig_d = sig_q;
      if (load) begin
         sig_d = MISR_SEED;
      end else if (en) begin
         sig_d = {sig_q[MISR_W-2:0], fb} ^ {{(MISR_W-7){1'b0}}, din};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering in simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= MISR_SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/gate_resp_checker.sv
// -----------------------------------------------------------------------------
// gate_resp_checker
//   Receive-side checker for the gate lab. Each accepted vector {a,b,c,d,e,f,g}
//   is compared against e=~(a&b), f=~(c|d), g=a^b^c^d; mismatches are counted
//   (saturating), the first failing vector and its index are latched, and every
//   vector is compressed into a MISR signature. A run accepts NUM_VEC vectors.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             begin a run (honoured in IDLE or DONE only)
//     vec_valid         a..g valid this cycle
//     a,b,c,d / e,f,g   gate stimulus / gate outputs under test
//     busy, done, pass  run status; pass = done && err_cnt == 0
//     err_cnt           mismatching vectors this run, saturating
//     first_err_idx/vec index and contents of first mismatch (valid with err_seen)
//     signature         MISR state (SIG_W must be 16)
// -----------------------------------------------------------------------------
module gate_resp_checker
   import gate_chk_pkg::*;
#(
   parameter  int NUM_VEC = 16,
   parameter  int CNT_W   = 8,
   parameter  int SIG_W   = 16,
   localparam int IW      = $clog2(NUM_VEC)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_valid,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             e,
   input  logic             f,
   input  logic             g,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [IW-1:0]    first_err_idx,
   output logic [6:0]       first_err_vec,
   output logic             err_seen,
   output logic [SIG_W-1:0] signature
);

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_seen_q, err_seen_d;
   logic [IW-1:0]    first_idx_q, first_idx_d;
   logic [6:0]       first_vec_q, first_vec_d;

   logic [6:0] vec;
   logic       mismatch;
   logic       load;
   logic       accept;
   logic       last;

   assign vec      = {a, b, c, d, e, f, g};
   assign mismatch = ({e, f, g} != expected_efg(a, b, c, d));
   // A start coinciding with vec_valid only opens the run; accept needs RUN
   // already registered, so that vector is dropped.
   assign load     = start && (state_q == ST_IDLE || state_q == ST_DONE);
   assign accept   = (state_q == ST_RUN) && vec_valid;
   assign last     = (idx_q == IW'(NUM_VEC - 1));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      err_cnt_d   = err_cnt_q;
      err_seen_d  = err_seen_q;
      first_idx_d = first_idx_q;
      first_vec_d = first_vec_q;

      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (accept && last) state_d = ST_DONE;
         ST_DONE: if (start) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         idx_d       = '0;
         err_cnt_d   = '0;
         err_seen_d  = 1'b0;
         first_idx_d = '0;
         first_vec_d = '0;
      end else if (accept) begin
         if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (!err_seen_q) begin
               err_seen_d  = 1'b1;
               first_idx_d = idx_q;
               first_vec_d = vec;
            end
         end
         // The last accept leaves the run, so idx is not advanced past it.
         if (!last) idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         err_cnt_q   <= '0;
         err_seen_q  <= 1'b0;
         first_idx_q <= '0;
         first_vec_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         err_cnt_q   <= err_cnt_d;
         err_seen_q  <= err_seen_d;
         first_idx_q <= first_idx_d;
         first_vec_q <= first_vec_d;
      end
   end

   gate_chk_misr u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .en   (accept),
      .din  (vec),
      .sig  (signature)
   );

   assign busy          = (state_q == ST_RUN);
   assign done          = (state_q == ST_DONE);
   assign pass          = done && (err_cnt_q == '0);
   assign err_cnt       = err_cnt_q;
   assign err_seen      = err_seen_q;
   assign first_err_idx = first_idx_q;
   assign first_err_vec = first_vec_q;

endmodule
